// File: rtl/ro_pkg.sv
// Shared helpers for the cochlea readout scheduler: width math, Gray encoding
// and the slot decode that maps a binary count to the channel it serves.
package ro_pkg;

   localparam int EVE     = 0;
   localparam int POL_EVE = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int ch_w(input int cnt_w);
      return (clog2(cnt_w) < 1) ? 1 : clog2(cnt_w);
   endfunction

   function automatic logic [31:0] gray_of(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Lowest set bit of (c+1) mod 2^cnt_w; a wrap to zero belongs to the top channel.
   function automatic int slot_of(input logic [31:0] c, input int cnt_w);
      logic [31:0] mask;
      logic [31:0] n;
      int          s;
      mask = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
      n    = (c + 32'd1) & mask;
      s    = cnt_w - 1;
      for (int i = 31; i >= 0; i--) begin
         if (n[i]) s = i;
      end
      return s;
   endfunction

endpackage

// File: rtl/ro_latch.sv
// Per-channel event holder: accumulates event bits between readout slots and
// flags a collision when a bit fires again while it is still pending.
module ro_latch
   import ro_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_ev,
   input  logic         clr,
   output logic [W-1:0] pend,
   output logic         ovf
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         ovf  <= 1'b0;
      end else if (clr) begin
         // The served word already carries this cycle's in_ev, so nothing is kept.
         pend <= '0;
         ovf  <= 1'b0;
      end else begin
         pend <= pend | in_ev;
         ovf  <= ovf | (|(pend & in_ev));
      end
   end

endmodule

// File: rtl/ro_sched.sv
// Time-slotted readout multiplexer: a free-running Gray count assigns each
// channel its own slot, and the served channel's word goes out on a registered bus.
module ro_sched
   import ro_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int W      = 2,
   parameter int CNT_W  = 4,
   parameter int STICKY = 1
) (
   input  logic                     clk_master,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N_CH*W-1:0]        in_ev,
   output logic [CNT_W-1:0]         gray,
   output logic                     ro_valid,
   output logic [ch_w(CNT_W)-1:0]   ro_ch,
   output logic [W-1:0]             ro_data,
   output logic                     ro_ovf,
   output logic                     frame
);

   localparam int CH_W = ch_w(CNT_W);

   logic [CNT_W-1:0] c;
   logic [CNT_W-1:0] c_next;
   int               slot;
   logic             slot_hit;
   logic [W-1:0]     sel_data;
   logic             sel_ovf;
   logic [N_CH-1:0]  clr;
   logic [W-1:0]     pend [N_CH];
   logic [N_CH-1:0]  ovf;

   always_comb begin
      c_next   = c + 1'b1;
      slot     = slot_of(32'(c), CNT_W);
      slot_hit = (slot < N_CH);
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         assign clr[gi] = en && (slot == gi);
         if (STICKY != 0) begin : g_sticky
            ro_latch #(.W(W)) u_latch (
               .clk   (clk_master),
               .rst   (rst),
               .in_ev (in_ev[gi*W +: W]),
               .clr   (clr[gi]),
               .pend  (pend[gi]),
               .ovf   (ovf[gi])
            );
         end else begin : g_plain
            assign pend[gi] = '0;
            assign ovf[gi]  = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      sel_data = '0;
      sel_ovf  = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (slot == k) begin
            sel_data = pend[k] | in_ev[k*W +: W];
            sel_ovf  = ovf[k];
         end
      end
   end

   // ro_ch and ro_data keep their last word; the pulse outputs drop each cycle.
   always_ff @(posedge clk_master or posedge rst) begin
      if (rst) begin
         c        <= '0;
         gray     <= '0;
         ro_valid <= 1'b0;
         ro_ch    <= '0;
         ro_data  <= '0;
         ro_ovf   <= 1'b0;
         frame    <= 1'b0;
      end else begin
         ro_valid <= 1'b0;
         ro_ovf   <= 1'b0;
         frame    <= 1'b0;
         if (en) begin
            c     <= c_next;
            gray  <= CNT_W'(gray_of(32'(c_next)));
            frame <= (c == '1);
            if (slot_hit) begin
               ro_valid <= 1'b1;
               ro_ch    <= CH_W'(slot);
               ro_data  <= sel_data;
               ro_ovf   <= sel_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_ro_sched.sv
// Directed bench for ro_sched: a vector table for the 4-channel sweep and latch
// behaviour, then hand sequences on a 2-channel instance for idle slots and async reset.
module tb_ro_sched;

   logic       clk;
   logic       rst4, en4;
   logic [7:0] ev4;
   logic [3:0] gray4;
   logic       v4, o4, f4;
   logic [1:0] ch4, d4;

   logic       rst2, en2;
   logic [3:0] ev2;
   logic [3:0] gray2;
   logic       v2, o2, f2;
   logic [1:0] ch2, d2;

   int total_cnt = 0;
   int pass_cnt  = 0;

   ro_sched #(.N_CH(4), .W(2), .CNT_W(4), .STICKY(1)) dut4 (
      .clk_master (clk), .rst (rst4), .en (en4), .in_ev (ev4),
      .gray (gray4), .ro_valid (v4), .ro_ch (ch4), .ro_data (d4),
      .ro_ovf (o4), .frame (f4)
   );

   ro_sched #(.N_CH(2), .W(2), .CNT_W(4), .STICKY(1)) dut2 (
      .clk_master (clk), .rst (rst2), .en (en2), .in_ev (ev2),
      .gray (gray2), .ro_valid (v2), .ro_ch (ch2), .ro_data (d2),
      .ro_ovf (o2), .frame (f2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en;
      logic [7:0] ev;
      logic       v;
      logic [1:0] ch;
      logic [1:0] d;
      logic       o;
      logic [3:0] g;
      logic       f;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input logic [7:0] ev, input logic v,
                      input logic [1:0] ch, input logic [1:0] d, input logic o,
                      input logic [3:0] g, input logic f);
      vec_t r;
      r.en = en; r.ev = ev; r.v = v; r.ch = ch; r.d = d; r.o = o; r.g = g; r.f = f;
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   initial begin
      rst4 = 1'b1; en4 = 1'b1; ev4 = '0;
      rst2 = 1'b1; en2 = 1'b1; ev2 = '0;

      // Sweep, in_ev idle: rows are indexed by the count before the advance.
      add(1, 8'h00, 1, 0, 0, 0,  1, 0);  // c0
      add(1, 8'h00, 1, 1, 0, 0,  3, 0);
      add(1, 8'h00, 1, 0, 0, 0,  2, 0);
      add(1, 8'h00, 1, 2, 0, 0,  6, 0);
      add(1, 8'h00, 1, 0, 0, 0,  7, 0);
      add(1, 8'h00, 1, 1, 0, 0,  5, 0);
      add(1, 8'h00, 1, 0, 0, 0,  4, 0);
      add(1, 8'h00, 1, 3, 0, 0, 12, 0);
      add(1, 8'h00, 1, 0, 0, 0, 13, 0);
      add(1, 8'h00, 1, 1, 0, 0, 15, 0);
      add(1, 8'h00, 1, 0, 0, 0, 14, 0);
      add(1, 8'h00, 1, 2, 0, 0, 10, 0);
      add(1, 8'h00, 1, 0, 0, 0, 11, 0);
      add(1, 8'h00, 1, 1, 0, 0,  9, 0);
      add(1, 8'h00, 1, 0, 0, 0,  8, 0);
      add(1, 8'h00, 1, 3, 0, 0,  0, 1);  // c15 wrap
      // Second frame: sticky ch1, ch2 overflow, ch0 same-edge event.
      add(1, 8'h00, 1, 0, 0, 0,  1, 0);  // c0
      add(1, 8'h00, 1, 1, 0, 0,  3, 0);
      add(1, 8'h04, 1, 0, 0, 0,  2, 0);  // ch1 <- 01
      add(1, 8'h00, 1, 2, 0, 0,  6, 0);
      add(1, 8'h00, 1, 0, 0, 0,  7, 0);
      add(1, 8'h00, 1, 1, 1, 0,  5, 0);  // ch1 delivers 01
      add(1, 8'h00, 1, 0, 0, 0,  4, 0);
      add(1, 8'h00, 1, 3, 0, 0, 12, 0);
      add(1, 8'h00, 1, 0, 0, 0, 13, 0);
      add(1, 8'h20, 1, 1, 0, 0, 15, 0);  // ch1 empty; ch2 <- 10
      add(1, 8'h20, 1, 0, 0, 0, 14, 0);  // ch2 collides
      add(1, 8'h00, 1, 2, 2, 1, 10, 0);  // ch2 10 with overflow
      add(1, 8'h03, 1, 0, 3, 0, 11, 0);  // ch0 same-edge 11
      add(1, 8'h00, 1, 1, 0, 0,  9, 0);
      add(1, 8'h00, 1, 0, 0, 0,  8, 0);  // ch0 not left pending
      add(1, 8'h00, 1, 3, 0, 0,  0, 1);
      // Third frame: overflow cleared, then a 5-cycle freeze with events.
      add(1, 8'h00, 1, 0, 0, 0,  1, 0);
      add(1, 8'h00, 1, 1, 0, 0,  3, 0);
      add(1, 8'h00, 1, 0, 0, 0,  2, 0);
      add(1, 8'h00, 1, 2, 0, 0,  6, 0);  // ch2 overflow gone
      add(1, 8'h00, 1, 0, 0, 0,  7, 0);  // c4
      add(0, 8'h08, 0, 0, 0, 0,  7, 0);
      add(0, 8'h08, 0, 0, 0, 0,  7, 0);
      add(0, 8'h40, 0, 0, 0, 0,  7, 0);
      add(0, 8'h00, 0, 0, 0, 0,  7, 0);
      add(0, 8'h00, 0, 0, 0, 0,  7, 0);
      add(1, 8'h00, 1, 1, 2, 1,  5, 0);  // c5 resumes: ch1 10 + overflow
      add(1, 8'h00, 1, 0, 0, 0,  4, 0);
      add(1, 8'h00, 1, 3, 1, 0, 12, 0);  // ch3 01

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.valid", 32'(v4), 0);
      check("rst.ch",    32'(ch4), 0);
      check("rst.data",  32'(d4), 0);
      check("rst.ovf",   32'(o4), 0);
      check("rst.gray",  32'(gray4), 0);
      check("rst.frame", 32'(f4), 0);
      rst4 = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         en4 = tbl[i].en;
         ev4 = tbl[i].ev;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d.valid", i), 32'(v4),    32'(tbl[i].v));
         check($sformatf("v%0d.ch", i),    32'(ch4),   32'(tbl[i].ch));
         check($sformatf("v%0d.data", i),  32'(d4),    32'(tbl[i].d));
         check($sformatf("v%0d.ovf", i),   32'(o4),    32'(tbl[i].o));
         check($sformatf("v%0d.gray", i),  32'(gray4), 32'(tbl[i].g));
         check($sformatf("v%0d.frame", i), 32'(f4),    32'(tbl[i].f));
      end
      en4 = 1'b1;
      ev4 = '0;

      // Two-channel instance: slots 2 and 3 are idle and ro_ch holds.
      begin
         logic [7:0] exp_v;
         logic [7:0] exp_c1;
         exp_v  = 8'b0111_0111;  // bit i = valid after advance from c=i
         exp_c1 = 8'b0010_0010;  // bit i = ro_ch after that advance
         rst2 = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("n2.c%0d.valid", i), 32'(v2), 32'(exp_v[i]));
            check($sformatf("n2.c%0d.ch", i),    32'(ch2), 32'(exp_c1[i]));
         end
      end
      check("n2.gray_c8", 32'(gray2), 32'd12);

      @(posedge clk);   // c8 -> ch0
      @(negedge clk);
      check("n2.c8.valid", 32'(v2), 1);
      ev2 = 4'b1100;
      @(posedge clk);   // c9 -> ch1 word with 11
      #1;
      ev2 = '0;
      check("n2.c9.valid", 32'(v2), 1);
      check("n2.c9.data",  32'(d2), 3);
      #1 rst2 = 1'b1;
      #1;
      check("arst.valid", 32'(v2), 0);
      check("arst.ch",    32'(ch2), 0);
      check("arst.data",  32'(d2), 0);
      check("arst.ovf",   32'(o2), 0);
      check("arst.gray",  32'(gray2), 0);
      check("arst.frame", 32'(f2), 0);
      @(negedge clk);
      check("arst.hold_valid", 32'(v2), 0);
      rst2 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post.valid", 32'(v2), 1);
      check("post.ch",    32'(ch2), 0);
      check("post.data",  32'(d2), 0);
      check("post.gray",  32'(gray2), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
